l15_data_ram_arbiter: RTL and testbench

Arbiter and sequencer for the L1.5 instruction-cache data memory. The memory is a single-port SCM/SRAM, so each cycle it serves either one fetch read or one refill write. This block shares the port between the lookup read path and the refill write path. It gives writes priority, bounds read starvation with a streak counter, enforces write-before-read ordering on the same address, and returns read data with a fixed one-cycle latency and a stable hold value. It sits between the L1.5 cache controller and the data memory wrapper.

---
 rtl/l15_data_ram_arbiter.sv | 95 +++++++++
 tb/tb_l15_data_ram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/l15_data_ram_arbiter.sv
// L1.5 instruction-cache data memory arbiter.
// Shares a single-port data memory between the lookup read path and the
// refill write path. Writes win by default, a streak counter bounds how long
// a pending read can be held off, and a same-address collision always lets
// the write go first so the later read observes the refilled data. Read data
// comes back one cycle after the grant and is held stable between reads.
module l15_data_ram_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 7,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_gnt_o,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  input  logic                    wr_req_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_wdata_i,
  output logic                    wr_gnt_o,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  // Counter increment that parks at the streak limit instead of wrapping;
  // same-address writes may keep winning after the limit is reached.
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v >= STREAK_MAX) ? v : v + STREAK_W'(1);
  endfunction

  logic [STREAK_W-1:0]   streak_q;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rdata_hold_p1;
  logic                  same_addr;
  logic                  streak_ok;

  // Stage 0: combinational arbitration and memory drive
  assign same_addr = (rd_addr_i == wr_addr_i);
  assign streak_ok = (streak_q < STREAK_MAX);

  // A write yields only to a pending read on a different address once the
  // streak limit is hit; a same-address write always goes first.
  assign wr_gnt_o = wr_req_i & (~rd_req_i | same_addr | streak_ok);
  assign rd_gnt_o = rd_req_i & ~wr_gnt_o;

  assign mem_req_o   = rd_gnt_o | wr_gnt_o;
  assign mem_write_o = wr_gnt_o;
  assign mem_addr_o  = wr_gnt_o ? wr_addr_i : (rd_gnt_o ? rd_addr_i : '0);
  assign mem_wdata_o = wr_gnt_o ? wr_wdata_i : '0;
  assign mem_be_o    = {BE_W{wr_gnt_o}};

  // Consecutive write grants while a read waits; any read grant or a cycle
  // without a read request resets the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (!rd_req_i || rd_gnt_o) begin
      streak_q <= '0;
    end else if (wr_gnt_o) begin
      streak_q <= sat_inc(streak_q);
    end
  end

  // Stage 1: read data returns from memory one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_gnt_o;
    end
  end

  // Capture the returned word so rd_rdata_o stays stable between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold_p1 <= '0;
    end else if (vld_p1) begin
      rdata_hold_p1 <= mem_rdata_i;
    end
  end

  assign rd_rvalid_o = vld_p1;
  assign rd_rdata_o  = vld_p1 ? mem_rdata_i : rdata_hold_p1;

endmodule

// File: tb/tb_l15_data_ram_arbiter.sv
// Directed testbench for l15_data_ram_arbiter with a behavioural single-port
// memory attached to the mem_* port.
module tb_l15_data_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rd_req_i;
  logic [6:0]  rd_addr_i;
  logic        rd_gnt_o;
  logic        rd_rvalid_o;
  logic [63:0] rd_rdata_o;
  logic        wr_req_i;
  logic [6:0]  wr_addr_i;
  logic [63:0] wr_wdata_i;
  logic        wr_gnt_o;
  logic        mem_req_o;
  logic        mem_write_o;
  logic [6:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_rdata_i;

  int n_assert = 0;
  int n_fail   = 0;

  l15_data_ram_arbiter #(
    .DATA_WIDTH(64), .ADDR_WIDTH(7), .MAX_WR_STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
    .wr_gnt_o(wr_gnt_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write at the edge, read data valid the next cycle,
  // a junk pattern otherwise so the hold path is exercised.
  logic [63:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_req_o && mem_write_o) mem[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= (mem_req_o && !mem_write_o) ? mem[mem_addr_o] : 64'h5A5A_5A5A_5A5A_5A5A;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic er, input logic ew, input logic [6:0] ea);
    chk({tag, "_rd_gnt"}, 64'(rd_gnt_o), 64'(er));
    chk({tag, "_wr_gnt"}, 64'(wr_gnt_o), 64'(ew));
    chk({tag, "_mem_req"}, 64'(mem_req_o), 64'(er | ew));
    chk({tag, "_mem_write"}, 64'(mem_write_o), 64'(ew));
    chk({tag, "_mem_be"}, 64'(mem_be_o), ew ? 64'hFF : 64'h0);
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(ea));
  endtask

  task automatic drive(input logic rr, input logic [6:0] ra, input logic wr,
                       input logic [6:0] wa, input logic [63:0] wd);
    rd_req_i   = rr;
    rd_addr_i  = ra;
    wr_req_i   = wr;
    wr_addr_i  = wa;
    wr_wdata_i = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ew;
    rst_n = 1'b0;
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk("rst_rdata", rd_rdata_o, 64'd0);
    chk("rst_streak", 64'(dut.streak_q), 64'd0);
    chk_grant("rst_idle", 1'b0, 1'b0, 7'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    rst_n = 1'b1;

    // Preload words 0..3 through the write path
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b0, 7'd0, 1'b1, 7'(i), 64'hA0 + 64'(i));
      #1;
      chk_grant("preload", 1'b0, 1'b1, 7'(i));
      chk("preload_wdata", mem_wdata_o, 64'hA0 + 64'(i));
    end
    tick();
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    #1;
    chk_grant("idle", 1'b0, 1'b0, 7'd0);
    chk("idle_wdata", mem_wdata_o, 64'd0);

    // Back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) begin
        chk("rd_rvalid", 64'(rd_rvalid_o), 64'd1);
        chk("rd_rdata", rd_rdata_o, 64'hA0 + 64'(i - 1));
      end else begin
        chk("rd_rvalid0", 64'(rd_rvalid_o), 64'd0);
      end
      drive(1'b1, 7'(i), 1'b0, 7'd0, 64'd0);
      #1;
      chk_grant("rd_only", 1'b1, 1'b0, 7'(i));
    end
    tick();
    chk("rd_last_rvalid", 64'(rd_rvalid_o), 64'd1);
    chk("rd_last_rdata", rd_rdata_o, 64'hA3);
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    tick();
    chk("rd_hold_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk("rd_hold_rdata", rd_rdata_o, 64'hA3);

    // Starvation bound: 4 writes then 1 read, repeating
    for (int k = 0; k < 10; k++) begin
      tick();
      drive(1'b1, 7'd9, 1'b1, 7'd5, 64'h100 + 64'(k));
      #1;
      ew = (k % 5) != 4;
      if (!ew) chk("starve_streak", 64'(dut.streak_q), 64'd4);
      chk_grant("starve", !ew, ew, ew ? 7'd5 : 7'd9);
    end
    tick();
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    #1;
    chk("starve_clr", 64'(dut.streak_q), 64'd0);

    // Hazard: same-address write wins even at the streak limit
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, 7'd3, 1'b1, 7'd5, 64'h200 + 64'(k));
      #1;
      chk_grant("hz_fill", 1'b0, 1'b1, 7'd5);
    end
    tick();
    drive(1'b1, 7'd3, 1'b1, 7'd3, 64'hDEAD);
    #1;
    chk("hz_streak", 64'(dut.streak_q), 64'd4);
    chk_grant("hazard", 1'b0, 1'b1, 7'd3);
    chk("hz_wdata", mem_wdata_o, 64'hDEAD);
    tick();
    drive(1'b1, 7'd3, 1'b0, 7'd0, 64'd0);
    #1;
    chk("hz_sat", 64'(dut.streak_q), 64'd4);
    chk_grant("hz_read", 1'b1, 1'b0, 7'd3);
    tick();
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    #1;
    chk("hz_rvalid", 64'(rd_rvalid_o), 64'd1);
    chk("hz_rdata", rd_rdata_o, 64'hDEAD);
    chk("hz_streak_clr", 64'(dut.streak_q), 64'd0);

    // Idle gap: streak of 2, one cycle without a read, then a full streak again
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(1'b1, 7'd9, 1'b1, 7'd5, 64'h300);
      #1;
      chk_grant("gap_pre", 1'b0, 1'b1, 7'd5);
    end
    tick();
    drive(1'b0, 7'd0, 1'b1, 7'd5, 64'h301);
    #1;
    chk("gap_streak2", 64'(dut.streak_q), 64'd2);
    chk_grant("gap_drop", 1'b0, 1'b1, 7'd5);
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b1, 7'd9, 1'b1, 7'd5, 64'h310 + 64'(k));
      #1;
      if (k == 0) chk("gap_streak0", 64'(dut.streak_q), 64'd0);
      ew = (k < 4);
      chk_grant("gap_resume", !ew, ew, ew ? 7'd5 : 7'd9);
    end
    tick();
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);

    // Reset clears a nonzero streak immediately
    tick();
    drive(1'b1, 7'd9, 1'b1, 7'd5, 64'h400);
    tick();
    tick();
    chk("rst2_pre_streak", 64'(dut.streak_q), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("rst2_streak", 64'(dut.streak_q), 64'd0);
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    tick();
    rst_n = 1'b1;

    // Reset with read data pending, plus a read granted during reset
    tick();
    drive(1'b1, 7'd1, 1'b0, 7'd0, 64'd0);
    #1;
    chk_grant("rst3_rd", 1'b1, 1'b0, 7'd1);
    tick();
    chk("rst3_pre_rvalid", 64'(rd_rvalid_o), 64'd1);
    chk("rst3_pre_rdata", rd_rdata_o, 64'hA1);
    drive(1'b1, 7'd2, 1'b0, 7'd0, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst3_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk("rst3_rdata", rd_rdata_o, 64'd0);
    chk("rst3_gnt", 64'(rd_gnt_o), 64'd1);
    tick();
    chk("rst3_no_rvalid", 64'(rd_rvalid_o), 64'd0);
    drive(1'b0, 7'd0, 1'b0, 7'd0, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk_grant("post_idle", 1'b0, 1'b0, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
